mmc3_irq_counter: RTL and testbench

Scanline IRQ generator for the multicart's MMC3-class mapper modes. It watches PPU A12 and counts filtered rising edges, one per rendered scanline. A CPU-programmable 8-bit down-counter raises the cartridge `irq` line when it expires. It sits beside the mapper address-translation logic, consuming the same CPU/PPU bus inputs, and drives the top-level `irq` pin that the translation block currently leaves floating.

---
 rtl/mmc3_irq_counter_pkg.sv | 19 +
 rtl/mmc3_irq_counter_if.sv | 17 +
 rtl/mmc3_irq_counter_a12_edge_filter.sv | 38 +++
 rtl/mmc3_irq_counter.sv | 106 ++++++++++
 tb/tb_mmc3_irq_counter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mmc3_irq_counter_pkg.sv
// Shared definitions for the MMC3-class scanline IRQ counter.
package mmc3_irq_pkg;

    // Register select within $C000-$FFFF, formed from {A13, A0}.
    typedef enum logic [1:0] {
        REG_LATCH   = 2'b00,  // $C000 even: reload value
        REG_RELOAD  = 2'b01,  // $C001 odd : clear counter, force reload
        REG_DISABLE = 2'b10,  // $E000 even: disable and acknowledge
        REG_ENABLE  = 2'b11   // $E001 odd : enable
    } reg_sel_e;

    // Low M2 samples that must precede an A12 rise for it to count.
    localparam int A12_FILTER_DEFAULT = 3;

    function automatic reg_sel_e decode_reg(input logic a13, input logic a0);
        return reg_sel_e'({a13, a0});
    endfunction

endpackage

// File: rtl/mmc3_irq_counter_if.sv
// CPU/PPU bus inputs shared with the mapper address-translation logic.
interface mmc3_irq_counter_if;
    logic        enable;
    logic        romsel;
    logic        cpu_rw_in;
    logic [14:0] cpu_addr_in;
    logic [7:0]  cpu_data_in;
    logic        ppu_a12;

    modport master (
        output enable, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12
    );

    modport slave (
        input enable, romsel, cpu_rw_in, cpu_addr_in, cpu_data_in, ppu_a12
    );
endinterface

// File: rtl/mmc3_irq_counter_a12_edge_filter.sv
// PPU A12 rise detector that ignores rises not preceded by a long enough
// low period, so only the once-per-scanline sprite fetch rise is counted.
module a12_edge_filter
    import mmc3_irq_pkg::*;
#(
    parameter int A12_FILTER = A12_FILTER_DEFAULT
) (
    input  logic i_m2,
    input  logic i_rst,
    input  logic i_a12,
    output logic o_a12_rise
);

    localparam int CW = (A12_FILTER < 1) ? 1 : $clog2(A12_FILTER + 1);
    localparam logic [CW-1:0] SAT = CW'(A12_FILTER);

    logic          r_a12_q;
    logic [CW-1:0] r_low_cnt;

    // Rise is judged against the samples taken before this one, so it is
    // valid in the same M2 period that A12 is first seen high.
    assign o_a12_rise = i_a12 & ~r_a12_q & (r_low_cnt >= SAT);

    // Track previous sample and a saturating count of consecutive lows.
    always_ff @(negedge i_m2 or posedge i_rst) begin
        if (i_rst) begin
            r_a12_q   <= 1'b0;
            r_low_cnt <= '0;
        end else begin
            r_a12_q <= i_a12;
            if (i_a12)
                r_low_cnt <= '0;
            else if (r_low_cnt != SAT)
                r_low_cnt <= r_low_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mmc3_irq_counter.sv
// MMC3-class scanline IRQ: CPU-programmable 8-bit down-counter clocked by
// filtered PPU A12 rises, driving an open-drain cartridge IRQ line.
module mmc3_irq_counter
    import mmc3_irq_pkg::*;
#(
    parameter int A12_FILTER = A12_FILTER_DEFAULT,
    parameter bit NEW_IRQ    = 1'b1
) (
    input  logic              m2,
    input  logic              rst,
    mmc3_irq_counter_if.slave bus,
    output logic              irq_pending,
    output wire               irq
);

    logic [7:0] r_latch;
    logic [7:0] r_counter;
    logic       r_reload;
    logic       r_irq_en;
    logic       r_irq_pending;

    logic       w_a12_rise;
    logic       w_wr_strobe;
    reg_sel_e   w_sel;
    logic       w_wr_latch;
    logic       w_wr_reload;
    logic       w_wr_disable;
    logic       w_wr_enable;
    logic       w_edge;
    logic [7:0] w_count_next;
    logic       w_zero_next;
    logic       w_fire;
    logic       w_unused_addr;

    a12_edge_filter #(
        .A12_FILTER (A12_FILTER)
    ) u_filter (
        .i_m2       (m2),
        .i_rst      (rst),
        .i_a12      (bus.ppu_a12),
        .o_a12_rise (w_a12_rise)
    );

    // Only A14, A13 and A0 take part in decoding.
    assign w_unused_addr = ^bus.cpu_addr_in[12:1];

    assign w_wr_strobe  = bus.enable & ~bus.cpu_rw_in & ~bus.romsel & bus.cpu_addr_in[14];
    assign w_sel        = decode_reg(bus.cpu_addr_in[13], bus.cpu_addr_in[0]);
    assign w_wr_latch   = w_wr_strobe && (w_sel == REG_LATCH);
    assign w_wr_reload  = w_wr_strobe && (w_sel == REG_RELOAD);
    assign w_wr_disable = w_wr_strobe && (w_sel == REG_DISABLE);
    assign w_wr_enable  = w_wr_strobe && (w_sel == REG_ENABLE);

    // A $C001 write in the same period swallows the scanline edge.
    assign w_edge       = w_a12_rise & bus.enable & ~w_wr_reload;

    // Zero always reloads, so the counter can never wrap below zero.
    assign w_count_next = (r_counter == 8'd0 || r_reload) ? r_latch : r_counter - 8'd1;
    assign w_zero_next  = (w_count_next == 8'd0);
    assign w_fire       = NEW_IRQ ? w_zero_next
                                  : (w_zero_next && (r_counter != 8'd0 || r_reload));

    // Reload value register; a reload on the same edge still sees the old value.
    always_ff @(negedge m2 or posedge rst) begin
        if (rst)
            r_latch <= 8'd0;
        else if (w_wr_latch)
            r_latch <= bus.cpu_data_in;
    end

    // Down-counter with forced-reload flag.
    always_ff @(negedge m2 or posedge rst) begin
        if (rst) begin
            r_counter <= 8'd0;
            r_reload  <= 1'b0;
        end else if (w_wr_reload) begin
            r_counter <= 8'd0;
            r_reload  <= 1'b1;
        end else if (w_edge) begin
            r_counter <= w_count_next;
            r_reload  <= 1'b0;
        end
    end

    // IRQ enable and sticky pending flag; acknowledge beats a same-edge fire.
    always_ff @(negedge m2 or posedge rst) begin
        if (rst) begin
            r_irq_en      <= 1'b0;
            r_irq_pending <= 1'b0;
        end else begin
            if (w_wr_disable)
                r_irq_en <= 1'b0;
            else if (w_wr_enable)
                r_irq_en <= 1'b1;

            if (w_wr_disable)
                r_irq_pending <= 1'b0;
            else if (w_edge && w_fire && r_irq_en)
                r_irq_pending <= 1'b1;
        end
    end

    assign irq_pending = r_irq_pending;
    assign irq         = (r_irq_pending & bus.enable) ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_mmc3_irq_counter.sv
// Bench for mmc3_irq_counter: both IRQ revisions side by side, directed
// scenarios followed by randomized A12 pulse trains and CPU writes.
module tb_mmc3_irq_counter;

    localparam int F = 3;

    logic m2;
    logic rst;
    wire  irq_a;
    wire  irq_b;
    logic pend_a;
    logic pend_b;

    pullup (irq_a);
    pullup (irq_b);

    mmc3_irq_counter_if bus ();

    mmc3_irq_counter #(.A12_FILTER(F), .NEW_IRQ(1'b0)) dut_a (
        .m2(m2), .rst(rst), .bus(bus), .irq_pending(pend_a), .irq(irq_a)
    );
    mmc3_irq_counter #(.A12_FILTER(F), .NEW_IRQ(1'b1)) dut_b (
        .m2(m2), .rst(rst), .bus(bus), .irq_pending(pend_b), .irq(irq_b)
    );

    initial m2 = 1'b0;
    always #5 m2 = ~m2;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state, index 0 = Rev-A, index 1 = Rev-B.
    int m_latch [2];
    int m_cnt   [2];
    bit m_rel   [2];
    bit m_en    [2];
    bit m_pend  [2];
    int zeros_run;   // consecutive low A12 samples since the last high one

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic reset_model();
        for (int m = 0; m < 2; m++) begin
            m_latch[m] = 0; m_cnt[m] = 0; m_rel[m] = 0; m_en[m] = 0; m_pend[m] = 0;
        end
        zeros_run = 0;
    endtask

    // One M2 falling edge, from the rules for writes, scanline clocks and IRQs.
    task automatic model_edge();
        bit qual, is_wr, is_reload, is_ack, fires;
        int full, nxt, old_cnt, old_latch;
        bit old_rel, old_en;
        qual  = bus.ppu_a12 && (zeros_run >= F);
        is_wr = bus.enable && !bus.cpu_rw_in && !bus.romsel;
        full  = 32'h8000 + int'(bus.cpu_addr_in);
        for (int m = 0; m < 2; m++) begin
            old_cnt = m_cnt[m]; old_rel = m_rel[m]; old_latch = m_latch[m]; old_en = m_en[m];
            is_reload = 0; is_ack = 0;
            if (is_wr && full >= 32'hC000 && full < 32'hE000) begin
                if (full % 2 == 0) m_latch[m] = int'(bus.cpu_data_in);
                else begin m_cnt[m] = 0; m_rel[m] = 1; is_reload = 1; end
            end
            if (is_wr && full >= 32'hE000) begin
                if (full % 2 == 0) begin m_en[m] = 0; m_pend[m] = 0; is_ack = 1; end
                else m_en[m] = 1;
            end
            if (bus.enable && qual && !is_reload) begin
                nxt = (old_cnt == 0 || old_rel) ? old_latch : old_cnt - 1;
                fires = (m == 1) ? (nxt == 0) : (nxt == 0 && (old_cnt != 0 || old_rel));
                m_cnt[m] = nxt;
                m_rel[m] = 0;
                if (fires && old_en && !is_ack) m_pend[m] = 1;
            end
        end
        zeros_run = bus.ppu_a12 ? 0 : zeros_run + 1;
    endtask

    task automatic compare_all();
        check("A_pending", pend_a,            m_pend[0]);
        check("A_counter", dut_a.r_counter,   m_cnt[0]);
        check("A_reload",  dut_a.r_reload,    m_rel[0]);
        check("A_latch",   dut_a.r_latch,     m_latch[0]);
        check("A_irq_en",  dut_a.r_irq_en,    m_en[0]);
        check("A_irq_low", irq_a === 1'b0,    m_pend[0] && bus.enable);
        check("B_pending", pend_b,            m_pend[1]);
        check("B_counter", dut_b.r_counter,   m_cnt[1]);
        check("B_reload",  dut_b.r_reload,    m_rel[1]);
        check("B_latch",   dut_b.r_latch,     m_latch[1]);
        check("B_irq_en",  dut_b.r_irq_en,    m_en[1]);
        check("B_irq_low", irq_b === 1'b0,    m_pend[1] && bus.enable);
    endtask

    // Drive inputs at the rising edge, act and compare just after the falling edge.
    task automatic cyc(input bit a12, input bit rw, input bit romsel,
                       input logic [14:0] addr, input logic [7:0] data);
        @(posedge m2);
        bus.ppu_a12     = a12;
        bus.cpu_rw_in   = rw;
        bus.romsel      = romsel;
        bus.cpu_addr_in = addr;
        bus.cpu_data_in = data;
        @(negedge m2);
        #1;
        if (rst) reset_model();
        else     model_edge();
        compare_all();
    endtask

    task automatic idle(input bit a12);
        cyc(a12, 1'b1, 1'b1, 15'h0000, 8'h00);
    endtask

    task automatic wr(input logic [14:0] addr, input logic [7:0] data);
        cyc(1'b0, 1'b0, 1'b0, addr, data);
    endtask

    task automatic pulse(input int lo, input int hi);
        for (int i = 0; i < lo; i++) idle(1'b0);
        for (int i = 0; i < hi; i++) idle(1'b1);
    endtask

    task automatic rcyc(input bit a12);
        logic [14:0] addr;
        logic [7:0]  data;
        bit          rw, rs;
        if ($urandom_range(0, 63) == 0) bus.enable = ~bus.enable;
        addr = 15'($urandom);
        if ($urandom_range(0, 3) != 0) addr[14] = 1'b1;
        data = 8'($urandom_range(0, 4));
        rw   = ($urandom_range(0, 4) != 0);
        rs   = ($urandom_range(0, 5) == 0);
        cyc(a12, rw, rs, addr, data);
    endtask

    initial begin
        rst             = 1'b1;
        bus.enable      = 1'b1;
        bus.romsel      = 1'b1;
        bus.cpu_rw_in   = 1'b1;
        bus.cpu_addr_in = 15'h0000;
        bus.cpu_data_in = 8'h00;
        bus.ppu_a12     = 1'b0;
        reset_model();
        repeat (2) idle(1'b0);
        rst = 1'b0;
        check("reset_pending", pend_b, 0);

        // Count 3,2,1,0 over four scanlines and raise the IRQ.
        wr(15'h4000, 8'd3);
        wr(15'h6001, 8'd0);
        repeat (4) pulse(4, 2);
        check("fourth_rise_pend_A", pend_a, 1);
        check("fourth_rise_pend_B", pend_b, 1);
        check("fourth_rise_irq", irq_b === 1'b0, 1);

        // Acknowledge and keep counting with the IRQ disabled.
        wr(15'h6000, 8'd0);
        check("ack_irq_released", irq_b === 1'b0, 0);
        repeat (4) pulse(4, 2);
        check("disabled_no_pend", pend_b, 0);

        // Glitch rejection: two low samples do not clock, three do.
        wr(15'h4000, 8'd10);
        wr(15'h4001, 8'd0);
        pulse(4, 2);
        pulse(2, 2);
        check("glitch_counter", dut_b.r_counter, 10);
        pulse(3, 2);
        check("three_low_counter", dut_b.r_counter, 9);

        // latch = 0: Rev-B fires every edge, Rev-A only after a forced reload.
        wr(15'h4000, 8'd0);
        wr(15'h4001, 8'd0);
        wr(15'h6001, 8'd0);
        pulse(4, 2);
        check("latch0_reload_A", pend_a, 1);
        wr(15'h6000, 8'd0);
        wr(15'h6001, 8'd0);
        pulse(4, 2);
        check("latch0_plain_A", pend_a, 0);
        check("latch0_plain_B", pend_b, 1);
        wr(15'h4001, 8'd0);
        pulse(4, 2);
        check("latch0_c001_A", pend_a, 1);

        // $C001 on the same edge as a qualified rise wins.
        wr(15'h6000, 8'd0);
        wr(15'h4000, 8'd5);
        wr(15'h4001, 8'd0);
        pulse(4, 2);
        check("collide_pre_counter", dut_b.r_counter, 5);
        for (int i = 0; i < 4; i++) idle(1'b0);
        cyc(1'b1, 1'b0, 1'b0, 15'h4001, 8'h00);
        check("collide_counter", dut_b.r_counter, 0);
        check("collide_reload", dut_b.r_reload, 1);
        idle(1'b1);
        pulse(4, 2);
        check("collide_next_load", dut_b.r_counter, 5);

        // Pending with counter 7, then enable drop and asynchronous reset.
        wr(15'h4000, 8'd1);
        wr(15'h4001, 8'd0);
        wr(15'h6001, 8'd0);
        pulse(4, 2);
        pulse(4, 2);
        wr(15'h4000, 8'd7);
        pulse(4, 2);
        check("pre_rst_counter", dut_a.r_counter, 7);
        check("pre_rst_pend", pend_a, 1);
        #2 bus.enable = 1'b0;
        #1;
        compare_all();
        check("enable_low_keeps_pend", pend_a, 1);
        bus.enable = 1'b1;
        #1 rst = 1'b1;
        #1;
        reset_model();
        compare_all();
        check("async_rst_counter", dut_a.r_counter, 0);
        check("async_rst_irq", irq_a === 1'b0, 0);
        idle(1'b0);
        rst = 1'b0;

        // Disabled mapper ignores writes and does not count.
        bus.enable = 1'b0;
        wr(15'h4000, 8'd9);
        wr(15'h4001, 8'd0);
        wr(15'h6001, 8'd0);
        pulse(4, 2);
        check("disabled_latch", dut_b.r_latch, 0);
        check("disabled_reload", dut_b.r_reload, 0);
        bus.enable = 1'b1;

        // Randomized pulse trains with interleaved bus traffic.
        for (int p = 0; p < 300; p++) begin
            int lo, hi;
            lo = $urandom_range(1, 5);
            hi = $urandom_range(1, 3);
            for (int i = 0; i < lo; i++) rcyc(1'b0);
            for (int i = 0; i < hi; i++) rcyc(1'b1);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
